ram_dp_init: RTL and testbench

//   Parametrised simple-dual-port synchronous RAM (one write port, one read port, one clock).

---
 rtl/ram_dp_init.sv | 176 +++++++++++++++++
 tb/tb_ram_dp_init.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_init.sv
// Simple-dual-port synchronous RAM with lane write masks, write-first bypass,
// 1- or 2-cycle read latency and a hardware fill sweep after reset or on request.
module ram_dp_init #(
    parameter int                      addr_size  = 8,
    parameter int                      data_size  = 8,
    parameter int                      lane_size  = 8,
    parameter int                      rd_latency = 1,
    parameter logic [data_size-1:0]    init_value = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_req,
    input  logic                               write_en,
    input  logic [data_size/lane_size-1:0]     write_mask,
    input  logic [addr_size-1:0]               write_adress,
    input  logic [data_size-1:0]               data_in,
    input  logic                               rd_en,
    input  logic [addr_size-1:0]               rd_adress,
    output logic [data_size-1:0]               data_out,
    output logic                               rd_valid,
    output logic                               init_busy
);

    localparam int LANES = data_size / lane_size;
    localparam int DEPTH = 2 ** addr_size;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [addr_size-1:0] cnt_reg, cnt_next;

    logic                 ready;
    logic                 wr_fire;
    logic                 rd_fire;

    logic [addr_size-1:0] mem_wr_addr;
    logic [data_size-1:0] mem_wr_data;
    logic [LANES-1:0]     mem_wr_lanes;

    logic [data_size-1:0] mem [DEPTH];
    logic [data_size-1:0] mem_q;

    logic                 v1_reg;
    logic                 loaded_reg;
    logic [LANES-1:0]     byp_mask_reg;
    logic [data_size-1:0] byp_data_reg;
    logic [data_size-1:0] merged;
    logic [data_size-1:0] stage1_data;

    // ------------------------------------------------------------------
    // Sweep / mode FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                if (cnt_reg == {addr_size{1'b1}}) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + addr_size'(1);
                end
            end
            READY: begin
                if (init_req) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready     = (state_reg == READY);
    assign init_busy = ~ready;
    assign wr_fire   = ready & write_en;
    assign rd_fire   = ready & rd_en;

    // The sweep borrows the single write port; user writes are locked out meanwhile.
    assign mem_wr_addr  = ready ? write_adress : cnt_reg;
    assign mem_wr_data  = ready ? data_in : init_value;
    assign mem_wr_lanes = ready ? (wr_fire ? write_mask : '0) : '1;

    // ------------------------------------------------------------------
    // Storage: not reset, so it maps onto block RAM with byte enables
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_wr_lanes[i]) begin
                mem[mem_wr_addr][i*lane_size +: lane_size] <= mem_wr_data[i*lane_size +: lane_size];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            mem_q <= mem[rd_adress];
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: capture colliding write lanes so the RAM read stays old-data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg       <= 1'b0;
            loaded_reg   <= 1'b0;
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
        end else begin
            v1_reg <= rd_fire;
            if (rd_fire) begin
                loaded_reg   <= 1'b1;
                byp_mask_reg <= (wr_fire && (write_adress == rd_adress)) ? write_mask : '0;
                byp_data_reg <= data_in;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[gi*lane_size +: lane_size] = byp_mask_reg[gi]
                ? byp_data_reg[gi*lane_size +: lane_size]
                : mem_q[gi*lane_size +: lane_size];
        end
    endgenerate

    // Until the first read after reset the RAM output register is meaningless.
    assign stage1_data = loaded_reg ? merged : '0;

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    generate
        if (rd_latency >= 2) begin : g_lat2
            logic [data_size-1:0] out_reg;
            logic                 v2_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                    v2_reg  <= 1'b0;
                end else begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        out_reg <= stage1_data;
                    end
                end
            end

            assign data_out = out_reg;
            assign rd_valid = v2_reg;
        end else begin : g_lat1
            assign data_out = stage1_data;
            assign rd_valid = v1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed and randomized checks of ram_dp_init: a 16-bit/latency-1 instance and an
// 8-bit/latency-2 instance with a non-zero fill value, both against array models.
module tb_ram_dp_init;

    logic        clk;
    logic        rst_n;

    // Instance A: 16 words x 16 bits, two lanes, latency 1, fill 0
    logic        init_req_a, we_a, re_a, rv_a, busy_a;
    logic [1:0]  wm_a;
    logic [3:0]  wa_a, ra_a;
    logic [15:0] di_a, do_a;

    // Instance B: 16 words x 8 bits, one lane, latency 2, fill 8'hA5
    logic        init_req_b, we_b, re_b, rv_b, busy_b;
    logic [0:0]  wm_b;
    logic [3:0]  wa_b, ra_b;
    logic [7:0]  di_b, do_b;

    logic [15:0] model_a [16];
    logic [7:0]  model_b [16];
    logic [15:0] last_a;
    logic [7:0]  last_b;
    logic        exp_v [$];
    logic [7:0]  exp_d [$];

    int checks;
    int errors;
    int n;

    ram_dp_init #(
        .addr_size (4),
        .data_size (16),
        .lane_size (8),
        .rd_latency(1),
        .init_value(16'h0000)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req    (init_req_a),
        .write_en    (we_a),
        .write_mask  (wm_a),
        .write_adress(wa_a),
        .data_in     (di_a),
        .rd_en       (re_a),
        .rd_adress   (ra_a),
        .data_out    (do_a),
        .rd_valid    (rv_a),
        .init_busy   (busy_a)
    );

    ram_dp_init #(
        .addr_size (4),
        .data_size (8),
        .lane_size (8),
        .rd_latency(2),
        .init_value(8'hA5)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req    (init_req_b),
        .write_en    (we_b),
        .write_mask  (wm_b),
        .write_adress(wa_b),
        .data_in     (di_b),
        .rd_en       (re_b),
        .rd_adress   (ra_b),
        .data_out    (do_b),
        .rd_valid    (rv_b),
        .init_busy   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance A; the model applies the write before the read (write-first).
    task automatic op_a(input logic we, input logic [1:0] m, input logic [3:0] wa,
                        input logic [15:0] din, input logic re, input logic [3:0] ra,
                        input string tag);
        logic [15:0] exp;
        we_a = we; wm_a = m; wa_a = wa; di_a = din; re_a = re; ra_a = ra;
        if (we) begin
            for (int i = 0; i < 2; i++) begin
                if (m[i]) model_a[wa][i*8 +: 8] = din[i*8 +: 8];
            end
        end
        exp = re ? model_a[ra] : last_a;
        step();
        check({tag, " valid"}, {31'd0, rv_a}, {31'd0, re});
        check({tag, " data"}, {16'd0, do_a}, {16'd0, exp});
        last_a = exp;
        we_a = 1'b0; re_a = 1'b0;
        $display("A %s we=%0d m=%0d wa=%0d din=%h re=%0d ra=%0d -> rv=%0d dout=%h",
                 tag, we, m, wa, din, re, ra, rv_a, do_a);
    endtask

    // One cycle on instance B; expectations travel through a queue two entries deep.
    task automatic op_b(input logic we, input logic m, input logic [3:0] wa,
                        input logic [7:0] din, input logic re, input logic [3:0] ra,
                        input string tag);
        logic       v;
        logic [7:0] d;
        we_b = we; wm_b = m; wa_b = wa; di_b = din; re_b = re; ra_b = ra;
        if (we && m) model_b[wa] = din;
        exp_v.push_back(re);
        exp_d.push_back(model_b[ra]);
        step();
        v = exp_v.pop_front();
        d = exp_d.pop_front();
        check({tag, " valid"}, {31'd0, rv_b}, {31'd0, v});
        if (v) last_b = d;
        check({tag, " data"}, {24'd0, do_b}, {24'd0, last_b});
        we_b = 1'b0; re_b = 1'b0;
        $display("B %s we=%0d wa=%0d din=%h re=%0d ra=%0d -> rv=%0d dout=%h",
                 tag, we, wa, din, re, ra, rv_b, do_b);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        init_req_a = 0; we_a = 0; re_a = 0; wm_a = 0; wa_a = 0; ra_a = 0; di_a = 0;
        init_req_b = 0; we_b = 0; re_b = 0; wm_b = 0; wa_b = 0; ra_b = 0; di_b = 0;
        last_a = 16'h0000;
        last_b = 8'h00;
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 16'h0000;
            model_b[i] = 8'hA5;
        end

        // Reset state and sweep length (T1)
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", {31'd0, busy_a}, 32'd1);
        check("reset valid", {31'd0, rv_a}, 32'd0);
        check("reset data", {16'd0, do_a}, 32'd0);
        check("reset busy B", {31'd0, busy_b}, 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check("T1 busy edges", n, 32'd16);
        check("T1 busy B done", {31'd0, busy_b}, 32'd0);
        $display("T1 sweep took %0d edges", n);

        for (int a = 0; a < 16; a++) op_a(0, 2'b00, 4'd0, 16'h0, 1, 4'(a), "T1 read");

        // Lane masks (T2)
        op_a(1, 2'b11, 4'd5, 16'h1234, 0, 4'd0, "T2 wr full");
        op_a(1, 2'b10, 4'd5, 16'hABCD, 0, 4'd0, "T2 wr high");
        op_a(1, 2'b00, 4'd5, 16'hFFFF, 0, 4'd0, "T2 wr nomask");
        op_a(0, 2'b00, 4'd0, 16'h0, 1, 4'd5, "T2 read");
        check("T2 merged", {16'd0, do_a}, 32'h0000AB34);

        // Read-during-write (T3)
        op_a(1, 2'b11, 4'd7, 16'h0011, 0, 4'd0, "T3 pre7");
        op_a(1, 2'b11, 4'd6, 16'h0066, 0, 4'd0, "T3 pre6");
        op_a(1, 2'b11, 4'd7, 16'h005A, 1, 4'd7, "T3 same");
        check("T3 write-first", {16'd0, do_a}, 32'h0000005A);
        op_a(1, 2'b11, 4'd7, 16'h0077, 1, 4'd6, "T3 other");
        check("T3 other old", {16'd0, do_a}, 32'h00000066);
        op_a(1, 2'b10, 4'd7, 16'hBEEF, 1, 4'd7, "T3 partial");
        check("T3 partial merge", {16'd0, do_a}, 32'h0000BE77);

        // Randomized traffic on A
        for (int k = 0; k < 300; k++) begin
            op_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
        end

        // Init request (T4)
        for (int a = 0; a < 16; a++) op_a(1, 2'b11, 4'(a), 16'hFFFF, 0, 4'd0, "T4 fill");
        init_req_a = 1; we_a = 1; wm_a = 2'b11; wa_a = 4'd3; di_a = 16'h1234; re_a = 1; ra_a = 4'd3;
        step();
        init_req_a = 0; we_a = 0; re_a = 0;
        check("T4 req cycle valid", {31'd0, rv_a}, 32'd1);
        check("T4 req cycle data", {16'd0, do_a}, 32'h00001234);
        check("T4 busy", {31'd0, busy_a}, 32'd1);
        last_a = 16'h1234;
        n = 0;
        while (busy_a && n < 100) begin
            we_a = 1; wm_a = 2'b11; wa_a = 4'($urandom_range(0, 15)); di_a = 16'($urandom);
            re_a = 1; ra_a = 4'($urandom_range(0, 15));
            step();
            check("T4 no valid", {31'd0, rv_a}, 32'd0);
            n++;
        end
        we_a = 0; re_a = 0;
        check("T4 busy edges", n, 32'd16);
        check("T4 hold", {16'd0, do_a}, 32'h00001234);
        for (int i = 0; i < 16; i++) model_a[i] = 16'h0000;
        for (int a = 0; a < 16; a++) op_a(0, 2'b00, 4'd0, 16'h0, 1, 4'(a), "T4 read");

        // Asynchronous reset mid-sweep (T5)
        op_a(1, 2'b11, 4'd2, 16'hC0DE, 0, 4'd0, "T5 wr");
        op_a(0, 2'b00, 4'd0, 16'h0, 1, 4'd2, "T5 rd");
        init_req_a = 1;
        step();
        init_req_a = 0;
        repeat (5) step();
        check("T5 busy mid", {31'd0, busy_a}, 32'd1);
        check("T5 hold pre", {16'd0, do_a}, 32'h0000C0DE);
        rst_n = 1'b0;
        #2;
        check("T5 data", {16'd0, do_a}, 32'd0);
        check("T5 valid", {31'd0, rv_a}, 32'd0);
        check("T5 busy", {31'd0, busy_a}, 32'd1);
        step();
        rst_n = 1'b1;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check("T5 busy edges", n, 32'd16);
        last_a = 16'h0000;
        for (int i = 0; i < 16; i++) model_a[i] = 16'h0000;
        op_a(0, 2'b00, 4'd0, 16'h0, 1, 4'd2, "T5 reread");

        // Latency 2 pipeline (T6)
        last_b = 8'h00;
        exp_v.push_back(1'b0);
        exp_d.push_back(8'h00);
        op_b(1, 1'b1, 4'd1, 8'h01, 0, 4'd0, "T6 wr1");
        op_b(1, 1'b1, 4'd2, 8'h02, 0, 4'd0, "T6 wr2");
        op_b(1, 1'b1, 4'd3, 8'h03, 0, 4'd0, "T6 wr3");
        op_b(0, 1'b0, 4'd0, 8'h00, 1, 4'd1, "T6 rd1");
        check("T6 edge1 none", {31'd0, rv_b}, 32'd0);
        op_b(0, 1'b0, 4'd0, 8'h00, 1, 4'd2, "T6 rd2");
        check("T6 edge2", {24'd0, do_b}, 32'h01);
        op_b(0, 1'b0, 4'd0, 8'h00, 1, 4'd3, "T6 rd3");
        check("T6 edge3", {24'd0, do_b}, 32'h02);
        op_b(0, 1'b0, 4'd0, 8'h00, 1, 4'd9, "T6 rd9");
        check("T6 edge4", {24'd0, do_b}, 32'h03);
        op_b(0, 1'b0, 4'd0, 8'h00, 0, 4'd0, "T6 idle");
        check("T6 fill value", {24'd0, do_b}, 32'hA5);
        op_b(1, 1'b1, 4'd4, 8'h3C, 1, 4'd4, "T6 rdw");
        op_b(0, 1'b0, 4'd0, 8'h00, 0, 4'd0, "T6 rdw out");
        check("T6 write-first", {24'd0, do_b}, 32'h3C);

        // Randomized traffic on B
        for (int k = 0; k < 200; k++) begin
            op_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
        end
        op_b(0, 1'b0, 4'd0, 8'h00, 0, 4'd0, "flush");
        op_b(0, 1'b0, 4'd0, 8'h00, 0, 4'd0, "flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
